// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised RS-232 receiver. It supports 5..9 data bits and none, odd or
// even parity. Each received character carries its own parity and framing
// error flags. The receiver detects a break, and it buffers characters in a
// small FIFO with a valid/ready handshake. It also provides line-idle and
// end-of-packet indications that are used for packet framing.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst_n          asynchronous active-low reset
//   rxd            serial input, asynchronous, idles high
//   rx_data        FIFO head data, LSB = first bit received (0 when empty)
//   rx_parity_err  FIFO head parity error flag
//   rx_frame_err   FIFO head framing error flag (stop bit sampled low)
//   rx_valid       FIFO non-empty
//   rx_ready       consumer takes the head when rx_valid && rx_ready
//   overrun        1-cycle pulse: completed character dropped, FIFO full
//   break_det      1-cycle pulse: break condition seen
//   rx_idle        line idle for at least IDLE_BITS bit times
//   end_of_packet  1-cycle pulse when rx_idle rises after received traffic
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 38400,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 rx_idle,
  output logic                 end_of_packet
);

  localparam int DIV_RAW = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TC_W    = $clog2(OVERSAMPLE);
  localparam int BC_W    = $clog2(DATA_BITS);
  localparam int GAP_MAX = IDLE_BITS * OVERSAMPLE;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int EW      = DATA_BITS + 2;
  localparam logic ODD   = (PARITY == 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BRK   = 3'd5;

  if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
    $error("uart_rx_param: OVERSAMPLE must be a power of 2 and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_param: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  // ---------------------------------------------------------------- tick gen
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + DIV_W'(1);
  end

  // ------------------------------------------------ synchroniser and filter
  logic [1:0] sync_q;
  logic [2:0] samp_q;
  logic       filt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      samp_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], rxd};
      if (tick) samp_q <= {samp_q[1:0], sync_q[1]};
    end
  end

  // The majority vote is combinational. A level change therefore reaches the
  // FSM once two of the three tick samples agree.
  assign filt = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

  // --------------------------------------------------------------------- FSM
  logic [2:0]           state_q, state_d;
  logic [TC_W-1:0]      tcnt_q, tcnt_d;
  logic [BC_W-1:0]      bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 pbit_q, pbit_d;
  logic                 push, push_ferr, brk_ev, bit_end;

  assign bit_end = (tcnt_q == TC_W'(OVERSAMPLE - 1));

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    pbit_d    = pbit_q;
    push      = 1'b0;
    push_ferr = 1'b0;
    brk_ev    = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: if (!filt) begin
          state_d = S_START;
          tcnt_d  = '0;
        end
        S_START: if (tcnt_q == TC_W'(OVERSAMPLE / 2 - 1)) begin
          tcnt_d  = '0;
          bcnt_d  = '0;
          perr_d  = 1'b0;
          pbit_d  = 1'b0;
          state_d = filt ? S_IDLE : S_DATA;   // a high mid-start bit is a false start
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
        S_DATA: if (bit_end) begin
          tcnt_d  = '0;
          shreg_d = {filt, shreg_q[DATA_BITS-1:1]};
          if (bcnt_q == BC_W'(DATA_BITS - 1)) begin
            bcnt_d  = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
        S_PAR: if (bit_end) begin
          tcnt_d  = '0;
          pbit_d  = filt;
          perr_d  = ((^shreg_q) ^ filt) != ODD;
          state_d = S_STOP;
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
        S_STOP: if (bit_end) begin
          tcnt_d = '0;
          if (filt) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else if (shreg_q == '0 && !pbit_q) begin
            brk_ev  = 1'b1;                   // all-zero frame: break, nothing stored
            state_d = S_BRK;
          end else begin
            push      = 1'b1;
            push_ferr = 1'b1;
            state_d   = S_BRK;
          end
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
        S_BRK: if (filt) state_d = S_IDLE;    // start bits are ignored until the line recovers
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      pbit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      pbit_q  <= pbit_d;
    end
  end

  // -------------------------------------------------------------------- FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          empty, full, pop, do_wr;
  logic [EW-1:0] head;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && rx_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO proceeds.
  assign do_wr = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_wr) wr_q <= wr_q + (AW+1)'(1);
      if (pop)   rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // NOTE: the storage array has no reset. Empty entries are never presented,
  // because the head outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_q[AW-1:0]] <= {push_ferr, perr_q, shreg_q};
  end

  assign head          = mem[rd_q[AW-1:0]];
  assign rx_valid      = !empty;
  assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_parity_err = rx_valid & head[DATA_BITS];
  assign rx_frame_err  = rx_valid & head[DATA_BITS+1];

  // ------------------------------------------- gap, packet end and pulses
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             got_q, got_d;
  logic             eop_d;
  logic             eop_q, ovr_q, brk_q;

  assign rx_idle = (gap_q == GAP_W'(GAP_MAX));

  always_comb begin
    gap_d = gap_q;
    if (state_q != S_IDLE)     gap_d = '0;
    else if (tick && !rx_idle) gap_d = gap_q + GAP_W'(1);
  end

  // The pulse fires on the edge where the counter saturates, so it shares its
  // first cycle with the rising rx_idle.
  assign eop_d = got_q && !rx_idle && (gap_d == GAP_W'(GAP_MAX));

  always_comb begin
    got_d = got_q;
    if (push || brk_ev) got_d = 1'b1;
    else if (eop_d)     got_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
      got_q <= 1'b0;
      eop_q <= 1'b0;
      ovr_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
      got_q <= got_d;
      eop_q <= eop_d;
      ovr_q <= push && full && !pop;
      brk_q <= brk_ev;
    end
  end

  assign overrun       = ovr_q;
  assign break_det     = brk_q;
  assign end_of_packet = eop_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Self-checking bench for uart_rx_param. The bench uses three instances:
// 8N1 (u_dut0), 8E1 (u_dut1) and 5N1 (u_dut2). Each instance runs at one bit
// per 16 clk. A table of frames checks the received character and its flags.
// Hand-written sequences cover idle/end-of-packet, overrun, break, glitch
// rejection and reset in the middle of a frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CF = 1843200;
  localparam int BR = 115200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rxd;
  logic [2:0] rdy;
  wire  [2:0] vl, pe, fe, ov, bk, idl, eop;
  wire  [7:0] d0, d1;
  wire  [4:0] d2;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY(0), .FIFO_DEPTH(4), .IDLE_BITS(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd[0]), .rx_data(d0), .rx_parity_err(pe[0]),
    .rx_frame_err(fe[0]), .rx_valid(vl[0]), .rx_ready(rdy[0]), .overrun(ov[0]),
    .break_det(bk[0]), .rx_idle(idl[0]), .end_of_packet(eop[0]));

  uart_rx_param #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY(2), .FIFO_DEPTH(4), .IDLE_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd[1]), .rx_data(d1), .rx_parity_err(pe[1]),
    .rx_frame_err(fe[1]), .rx_valid(vl[1]), .rx_ready(rdy[1]), .overrun(ov[1]),
    .break_det(bk[1]), .rx_idle(idl[1]), .end_of_packet(eop[1]));

  uart_rx_param #(.CLK_FREQ(CF), .BAUD(BR), .OVERSAMPLE(16), .DATA_BITS(5),
                  .PARITY(0), .FIFO_DEPTH(4), .IDLE_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd[2]), .rx_data(d2), .rx_parity_err(pe[2]),
    .rx_frame_err(fe[2]), .rx_valid(vl[2]), .rx_ready(rdy[2]), .overrun(ov[2]),
    .break_det(bk[2]), .rx_idle(idl[2]), .end_of_packet(eop[2]));

  // ------------------------------------------------------------ monitor
  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } pop_t;

  pop_t popq[$];
  int   ov_cnt[3], bk_cnt[3], eop_cnt[3], vcyc[3];

  function automatic logic [8:0] dsel(int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return {4'b0, d2};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vl[i]) vcyc[i]++;
      if (vl[i] && rdy[i]) popq.push_back('{i, dsel(i), pe[i], fe[i]});
      if (ov[i])  ov_cnt[i]++;
      if (bk[i])  bk_cnt[i]++;
      if (eop[i]) eop_cnt[i]++;
    end
  end

  // ------------------------------------------------------------ helpers
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    popq.delete();
    for (int i = 0; i < 3; i++) begin
      ov_cnt[i] = 0; bk_cnt[i] = 0; eop_cnt[i] = 0; vcyc[i] = 0;
    end
  endtask

  task automatic bit_out(int i, logic v);
    rxd[i] = v;
    cyc(16);
  endtask

  // par < 0 means no parity bit; otherwise par[0] is sent as the parity bit.
  task automatic send(int i, logic [8:0] data, int nbits, int par, logic stop);
    bit_out(i, 1'b0);
    for (int k = 0; k < nbits; k++) bit_out(i, data[k]);
    if (par >= 0) bit_out(i, par[0]);
    bit_out(i, stop);
    rxd[i] = 1'b1;
  endtask

  task automatic check_one(string name, logic [8:0] ed, logic epe, logic efe);
    check({name, "_count"}, popq.size(), 1);
    if (popq.size() > 0) begin
      check({name, "_data"}, popq[0].data, ed);
      check({name, "_perr"}, popq[0].pe, epe);
      check({name, "_ferr"}, popq[0].fe, efe);
    end
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    int         inst;
    logic [8:0] data;
    int         par;
    logic       stop;
    logic [8:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 9'h0A5, -1, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h000, -1, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h0FF, -1, 1'b1, 9'h0FF, 1'b0, 1'b0};
    vecs[3]  = '{0, 9'h080, -1, 1'b0, 9'h080, 1'b0, 1'b1};
    vecs[4]  = '{1, 9'h007,  0, 1'b1, 9'h007, 1'b1, 1'b0};
    vecs[5]  = '{1, 9'h007,  1, 1'b1, 9'h007, 1'b0, 1'b0};
    vecs[6]  = '{1, 9'h000,  0, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[7]  = '{1, 9'h0FF,  1, 1'b1, 9'h0FF, 1'b1, 1'b0};
    vecs[8]  = '{1, 9'h000,  1, 1'b0, 9'h000, 1'b1, 1'b1};
    vecs[9]  = '{2, 9'h01F, -1, 1'b0, 9'h01F, 1'b0, 1'b1};
    vecs[10] = '{2, 9'h00A, -1, 1'b1, 9'h00A, 1'b0, 1'b0};
    vecs[11] = '{2, 9'h015, -1, 1'b1, 9'h015, 1'b0, 1'b0};

    rxd   = 3'b111;
    rdy   = 3'b111;
    rst_n = 1'b0;
    clr();
    cyc(3);

    // Reset state
    check("reset_flags", {vl, pe, fe, ov, bk, idl, eop}, 0);
    check("reset_data", {d0, d1, d2}, 0);
    rst_n = 1'b1;
    cyc(40);
    check("idle_after_reset", idl, 3'b111);
    check("no_eop_without_char", eop_cnt[0] + eop_cnt[1] + eop_cnt[2], 0);

    // 8N1 0xA5, then idle and end of packet
    clr();
    send(0, 9'h0A5, 8, -1, 1'b1);
    check("idle_low_after_frame", idl[0], 1'b0);
    cyc(512);
    check_one("a5", 9'h0A5, 1'b0, 1'b0);
    check("a5_valid_cycles", vcyc[0], 1);
    check("a5_idle", idl[0], 1'b1);
    check("a5_eop_once", eop_cnt[0], 1);

    // Table-driven frames across the three frame formats
    for (int v = 0; v < 12; v++) begin
      clr();
      send(vecs[v].inst, vecs[v].data, (vecs[v].inst == 2) ? 5 : 8, vecs[v].par, vecs[v].stop);
      cyc(48);
      check_one($sformatf("vec%0d", v), vecs[v].exp_d, vecs[v].exp_pe, vecs[v].exp_fe);
      check($sformatf("vec%0d_no_break", v), bk_cnt[vecs[v].inst], 0);
    end

    // Overrun: stall the consumer and send 0x01..0x05
    cyc(64);
    clr();
    rdy[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send(0, 9'(k), 8, -1, 1'b1);
      cyc(16);
    end
    check("ovr_none_before_5th", ov_cnt[0], 0);
    check("ovr_head_stable", {vl[0], d0}, {1'b1, 8'h01});
    send(0, 9'h005, 8, -1, 1'b1);
    cyc(16);
    check("ovr_once_on_5th", ov_cnt[0], 1);
    check("ovr_no_pop_while_stalled", popq.size(), 0);
    rdy[0] = 1'b1;
    cyc(10);
    check("ovr_pop_count", popq.size(), 4);
    for (int k = 0; k < 4 && k < popq.size(); k++)
      check($sformatf("ovr_pop%0d", k), popq[k].data, k + 1);
    check("ovr_drained", vl[0], 1'b0);

    // Break: hold low for 20 bit times, then a normal character
    cyc(64);
    clr();
    rxd[0] = 1'b0;
    cyc(320);
    rxd[0] = 1'b1;
    cyc(64);
    check("brk_once", bk_cnt[0], 1);
    check("brk_no_push", popq.size(), 0);
    check("brk_eop", eop_cnt[0], 1);
    clr();
    send(0, 9'h055, 8, -1, 1'b1);
    cyc(64);
    check_one("after_brk_55", 9'h055, 1'b0, 1'b0);

    // Glitch rejection: a 4-clk low pulse on an idle line
    check("glitch_pre_idle", idl[0], 1'b1);
    clr();
    rxd[0] = 1'b0;
    cyc(4);
    rxd[0] = 1'b1;
    cyc(6);
    check("glitch_left_idle", idl[0], 1'b0);
    cyc(64);
    check("glitch_no_push", popq.size(), 0);
    check("glitch_no_break", bk_cnt[0], 0);
    check("glitch_back_idle", idl[0], 1'b1);
    check("glitch_no_eop", eop_cnt[0], 0);

    // Reset during bit 3 of 0x3C, with one character already buffered
    clr();
    rdy[0] = 1'b0;
    send(0, 9'h099, 8, -1, 1'b1);
    cyc(16);
    check("rst_prefill_valid", vl[0], 1'b1);
    bit_out(0, 1'b0);
    bit_out(0, 1'b0);
    bit_out(0, 1'b0);
    bit_out(0, 1'b1);
    rxd[0] = 1'b1;
    cyc(8);
    rst_n = 1'b0;
    cyc(2);
    check("midrst_flags", {vl[0], pe[0], fe[0], ov[0], bk[0], idl[0], eop[0]}, 0);
    check("midrst_data", d0, 0);
    rst_n = 1'b1;
    cyc(48);
    rdy[0] = 1'b1;
    cyc(4);
    check("midrst_discarded", popq.size(), 0);
    send(0, 9'h03C, 8, -1, 1'b1);
    cyc(48);
    check_one("after_rst_3c", 9'h03C, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
